multiword_add_seq: RTL and testbench
====================================

# multiword_add_seq

Sequencer that performs wide additions (16·WORDS bits) by reusing the team's 16-bit carry-lookahead adder (ports c, x, y, finResult[16:0]) over several cycles. The block sits directly upstream of the adder: it drives x, y and c with one 16-bit slice per cycle. It also sits downstream of it: it captures finResult, chains bit 16 into the next slice's carry-in, and assembles the full sum. Operands enter and results leave through valid/ready handshakes.

## Interface
- WORDS, 4, number of 16-bit slices; operand width W = 16·WORDS; legal range 2..16
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low; the block has one clock
- in_valid  input  1  operand set valid
- in_ready  output  1  block can accept an operand set
- a  input  W  operand A
- b  input  W  operand B
- cin  input  1  carry-in to slice 0
- add_x  output  16  to adder x: current slice of A
- add_y  output  16  to adder y: current slice of B
- add_c  output  1  to adder c: running carry
- add_res  input  17  from adder finResult: {carry-out, sum[15:0]}, combinational from add_x/add_y/add_c
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  W  A + B + cin, modulo 2^W
- cout  output  1  unsigned carry-out of bit W-1
- ovf  output  1  two's-complement overflow

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b; set carry register to cin; set idx=0; clear sum register; go to RUN.
- RUN:
  - in_ready=0.
  - add_x = a_reg[16·idx+15:16·idx], add_y = b_reg slice idx, add_c = carry register.
  - At each edge: sum slice idx ← add_res[15:0]; carry ← add_res[16]; idx ← idx+1.
  - When the slice at idx=WORDS-1 is captured, go to DONE.
  - idx width is ceil(log2(WORDS)). idx never wraps within an operation.
- DONE:
  - out_valid=1. sum holds the assembled result.
  - cout = final carry register.
  - ovf = (a_reg[W-1]==b_reg[W-1]) && (sum[W-1]!=a_reg[W-1]).
  - On out_valid&&out_ready: go to IDLE.
- Outside RUN, add_x, add_y and add_c are driven to 0.
- sum, cout and ovf retain their values after leaving DONE until the next acceptance clears them. They are valid only while out_valid=1.
- in_valid is ignored outside IDLE. a, b and cin are sampled only at the acceptance edge; later changes have no effect.
- The result handshake and a new acceptance never occur on the same edge. in_ready rises in the cycle after the result handshake.
- Reset (rst_n low, any state, including mid-RUN):
  - Immediately force state=IDLE, idx=0, carry=0.
  - Force a_reg, b_reg, sum, cout and ovf to 0.
  - Outputs go to reset values without waiting for clk. The partial operation is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, add_x=0, add_y=0, add_c=0.
- Acceptance at edge E0 → slice k is captured at edge E(k+1).
- out_valid rises after edge E(WORDS); latency = WORDS cycles from acceptance.
- Minimum issue interval is WORDS+2 cycles (RUN ×WORDS, DONE ×1, IDLE ×1).
- While out_valid=1 and out_ready=0: sum, cout, ovf and out_valid hold stable indefinitely; in_ready stays 0.
- The adder path (add_x/add_y/add_c → add_res → sum register) is a single-cycle combinational path. No multicycle constraint applies.
- All outputs are registered or decoded from state/idx registers only. No input-to-output combinational path exists except through add_res into the registers.

## Test plan
All scenarios use WORDS=4, with the real 16-bit CLA connected to the adder ports.
- a=15, b=1, cin=0 → sum=16, cout=0, ovf=0. out_valid rises exactly 4 cycles after acceptance.
- a=0x0000_0000_0000_FFFF, b=0x258, cin=1 → sum=0x0000_0000_0001_0258. Also check slice-1 add_c=1 during the second RUN cycle.
- a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=0, cout=1, ovf=0. The carry must ripple through all four slices.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1 → sum=0x8000_0000_0000_0000, cout=0, ovf=1. Then a=b=0x8000_0000_0000_0000 → sum=0, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 6 cycles while toggling in_valid, a and b → sum, cout and ovf stay constant and in_ready=0. Release out_ready → in_ready=1 one cycle later; the next operation (3+3) gives sum=6.
- Drop rst_n low asynchronously after 2 slices of a=b=0x1111_1111_1111_1111 → all outputs take reset values before the next clk edge. After release, run a=12240, b=32768 → sum=45008, out_valid after 4 cycles.

Source files
------------

// File: rtl/multiword_add_seq.sv
// Multi-cycle wide adder: feeds an external 16-bit adder one slice per cycle,
// chains its carry-out into the next slice, and assembles the 16*WORDS-bit sum.
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  cin,
  output logic [15:0]           add_x,
  output logic [15:0]           add_y,
  output logic                  add_c,
  input  logic [16:0]           add_res,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    sum_reg;
  logic            cout_reg;
  logic            ovf_reg;

  // NOTE: every register here uses <= so all updates see pre-edge values,
  // which is what lets the carry feed back through the adder without a race.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= a;
            b_reg    <= b;
            carry    <= cin;
            idx      <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_reg[16*idx +: 16] <= add_res[15:0];
          carry                 <= add_res[16];
          if (idx == LAST) begin
            // Result flags are frozen here so they survive the trip back to IDLE.
            cout_reg <= add_res[16];
            ovf_reg  <= (a_reg[W-1] == b_reg[W-1]) && (add_res[15] != a_reg[W-1]);
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: defaults first so no path leaves an output unassigned (no latches).
  always_comb begin
    add_x = '0;
    add_y = '0;
    add_c = 1'b0;
    if (state == RUN) begin
      add_x = a_reg[16*idx +: 16];
      add_y = b_reg[16*idx +: 16];
      add_c = carry;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq (WORDS=4) with a behavioural
// 16-bit adder on the adder ports and a result scoreboard queue.
module tb_multiword_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic [15:0]   add_x;
  logic [15:0]   add_y;
  logic          add_c;
  logic [16:0]   add_res;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    exp_t         e;
  } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  assign add_res = {1'b0, add_x} + {1'b0, add_y} + {16'd0, add_c};

  multiword_add_seq #(.WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .add_x(add_x), .add_y(add_y), .add_c(add_c), .add_res(add_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    logic [W:0] full;
    exp_t e;
    full   = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (ta[W-1] == tb_v[W-1]) && (full[W-1] != ta[W-1]);
    return e;
  endfunction

  // Scoreboard: compare each completed result against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum",  sum,  e.sum);
        check("cout", W'(cout), W'(e.cout));
        check("ovf",  W'(ovf),  W'(e.ovf));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", W'(in_ready), W'(1));
  endtask

  // Issue one operand set, check slice drive during RUN and the 4-cycle latency.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input exp_t e, input bit chk_c1);
    wait_ready();
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = '0; cin = ~tc;
    for (int k = 0; k < WORDS; k++) begin
      check($sformatf("add_x_s%0d", k), W'(add_x), W'(ta[16*k +: 16]));
      check($sformatf("add_y_s%0d", k), W'(add_y), W'(tb_v[16*k +: 16]));
      check($sformatf("run_out_valid_s%0d", k), W'(out_valid), W'(0));
      if (chk_c1 && k == 1) check("slice1_add_c", W'(add_c), W'(1));
      @(posedge clk); #1;
    end
    check("latency_out_valid", W'(out_valid), W'(1));
    check("done_add_x", W'(add_x), W'(0));
  endtask

  vec_t tbl[$];

  initial begin
    exp_t e;
    logic [W-1:0] last_sum;
    vec_t v;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    #1;
    check("rst_in_ready",  W'(in_ready),  W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_sum",       sum,           '0);
    check("rst_add_x",     W'(add_x),     W'(0));
    @(negedge clk);
    rst_n = 1'b1;

    tbl.push_back('{a: 64'd15, b: 64'd1, cin: 1'b0,
                    e: '{sum: 64'd16, cout: 1'b0, ovf: 1'b0}});
    tbl.push_back('{a: 64'h0000_0000_0000_FFFF, b: 64'h258, cin: 1'b1,
                    e: '{sum: 64'h0000_0000_0001_0258, cout: 1'b0, ovf: 1'b0}});
    tbl.push_back('{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd1, cin: 1'b0,
                    e: '{sum: 64'd0, cout: 1'b1, ovf: 1'b0}});
    tbl.push_back('{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'd1, cin: 1'b0,
                    e: '{sum: 64'h8000_0000_0000_0000, cout: 1'b0, ovf: 1'b1}});
    tbl.push_back('{a: 64'h8000_0000_0000_0000, b: 64'h8000_0000_0000_0000, cin: 1'b0,
                    e: '{sum: 64'd0, cout: 1'b1, ovf: 1'b1}});
    tbl.push_back('{a: 64'h1234_5678_9ABC_DEF0, b: 64'h0FED_CBA9_8765_4321, cin: 1'b0,
                    e: '{sum: 64'h2222_2222_2222_2211, cout: 1'b0, ovf: 1'b0}});
    for (int i = 0; i < 8; i++) begin
      v.a   = {$urandom(), $urandom()};
      v.b   = {$urandom(), $urandom()};
      v.cin = 1'($urandom_range(0, 1));
      v.e   = model(v.a, v.b, v.cin);
      tbl.push_back(v);
    end

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].e, (i == 1));
      last_sum = tbl[i].e.sum;
    end
    wait_ready();
    check("retain_sum_in_idle", sum, last_sum);

    // Backpressure: result must hold while the consumer stalls.
    out_ready = 1'b0;
    e = '{sum: 64'h8000_0000_0000_0000, cout: 1'b0, ovf: 1'b1};
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, e, 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      @(negedge clk);
      check("bp_sum",       sum,            e.sum);
      check("bp_cout",      W'(cout),       W'(e.cout));
      check("bp_ovf",       W'(ovf),        W'(e.ovf));
      check("bp_in_ready",  W'(in_ready),   W'(0));
      check("bp_out_valid", W'(out_valid),  W'(1));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    check("bp_in_ready_before_release", W'(in_ready), W'(0));
    @(posedge clk); #1;
    check("in_ready_after_release", W'(in_ready), W'(1));
    run_op(64'd3, 64'd3, 1'b0, '{sum: 64'd6, cout: 1'b0, ovf: 1'b0}, 1'b0);

    // Asynchronous reset in the middle of an operation.
    wait_ready();
    a = 64'h1111_1111_1111_1111; b = 64'h1111_1111_1111_1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    check("pre_rst_partial_sum", sum, 64'h0000_0000_2222_2222);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready",  W'(in_ready),  W'(1));
    check("arst_out_valid", W'(out_valid), W'(0));
    check("arst_sum",       sum,           '0);
    check("arst_cout",      W'(cout),      W'(0));
    check("arst_ovf",       W'(ovf),       W'(0));
    check("arst_add_xyc",   W'({add_x, add_y, add_c}), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_op(64'd12240, 64'd32768, 1'b0, '{sum: 64'd45008, cout: 1'b0, ovf: 1'b0}, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
